// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall detection, taken-branch flush,
// and a halt sequence that drains the pipe before asserting halted.
// Handshake: the controller has no valid/ready pairs; it drives level
// enables (pc_write, ifid_write) and one-cycle squash strobes (ifid_flush,
// idex_bubble) that the datapath obeys in the same cycle they are asserted.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_opcode,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             ex_mem_to_reg,
    input  logic [3:0]       ex_rd,
    input  logic             br_taken,
    input  logic             id_halt,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_drain_ctr;
    logic [DW-1:0]    w_drain_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_use_rs;
    logic             w_use_rt;
    logic             w_hazard;
    logic             w_stall_inc;
    logic             w_flush_inc;

    // Source-operand usage decode and load-use hazard detection.
    assign w_use_rs = (id_opcode <= 4'd9);
    assign w_use_rt = (id_opcode <= 4'd4) || (id_opcode == 4'd9);
    assign w_hazard = ex_mem_to_reg && (ex_rd != 4'd0) &&
                      ((w_use_rs && (ex_rd == id_rs)) ||
                       (w_use_rt && (ex_rd == id_rt)));

    // State and drain counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_drain_ctr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_ctr <= w_drain_nxt;
        end
    end

    // Next-state logic: branch beats stall beats halt in RUN; DRAIN counts down.
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_ctr;
        case (r_state)
            ST_RUN: begin
                if (!br_taken && !w_hazard && id_halt) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (r_drain_ctr == '0) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_drain_nxt = r_drain_ctr - 1'b1;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Mealy outputs from state and inputs; reset forces a squashed, stopped pipe.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (br_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        w_flush_inc = 1'b1;
                    end else if (w_hazard) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        w_stall_inc = 1'b1;
                    end else if (id_halt) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                default: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    halted      = 1'b1;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance plus a
// CNT_W=4 / DRAIN_CYCLES=1 instance driven by the same inputs.
module tb_pipe_hazard_ctrl;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  id_opcode;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic        ex_mem_to_reg;
    logic [3:0]  ex_rd;
    logic        br_taken;
    logic        id_halt;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  dbg_state;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_halted;
    logic [3:0]  s_stall_cnt, s_flush_cnt;
    logic [1:0]  s_dbg_state;

    int n_cmp;
    int n_err;

    pipe_hazard_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs),
        .id_rt(id_rt), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
        .br_taken(br_taken), .id_halt(id_halt), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .halted(halted), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .dbg_state(dbg_state)
    );

    pipe_hazard_ctrl #(.DRAIN_CYCLES(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs),
        .id_rt(id_rt), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
        .br_taken(br_taken), .id_halt(id_halt), .pc_write(s_pc_write),
        .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .halted(s_halted), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt), .dbg_state(s_dbg_state)
    );

    // Clock / reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Checker: one comparison, one report line on mismatch.
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        id_opcode     = 4'hF;
        id_rs         = 4'd1;
        id_rt         = 4'd2;
        ex_mem_to_reg = 1'b0;
        ex_rd         = 4'd0;
        br_taken      = 1'b0;
        id_halt       = 1'b0;
    endtask

    task automatic drive_lw_use(input logic [3:0] op, input logic [3:0] rs,
                                input logic [3:0] rt, input logic [3:0] rd);
        id_opcode     = op;
        id_rs         = rs;
        id_rt         = rt;
        ex_mem_to_reg = 1'b1;
        ex_rd         = rd;
    endtask

    task automatic check_outs(input string tag, input logic pc, input logic iw,
                              input logic fl, input logic bb, input logic hl);
        check_eq({tag, ".pc_write"},    {31'd0, pc_write},    {31'd0, pc});
        check_eq({tag, ".ifid_write"},  {31'd0, ifid_write},  {31'd0, iw});
        check_eq({tag, ".ifid_flush"},  {31'd0, ifid_flush},  {31'd0, fl});
        check_eq({tag, ".idex_bubble"}, {31'd0, idex_bubble}, {31'd0, bb});
        check_eq({tag, ".halted"},      {31'd0, halted},      {31'd0, hl});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive_idle();
        #1;

        // Reset: forced outputs and cleared state.
        check_outs("rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        check_outs("rst2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("rst.state", {30'd0, dbg_state}, {30'd0, S_RUN});
        check_eq("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check_eq("rst.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        rst_n = 1'b1;
        #1;
        check_outs("run_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // No-stall cases: ex_rd=0, llb does not read rs, opcode 0101 does not read rt.
        drive_lw_use(4'b0000, 4'd0, 4'd7, 4'd0);
        #1;
        check_outs("rd0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive_lw_use(4'b1011, 4'd5, 4'd7, 4'd5);
        #1;
        check_outs("llb", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive_lw_use(4'b0101, 4'd2, 4'd5, 4'd5);
        #1;
        check_outs("op5_rt", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive_idle();
        #1;
        check_eq("nostall.stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // Load-use on rs: lw r3 in EX, add rs=3 in ID.
        drive_lw_use(4'b0000, 4'd3, 4'd7, 4'd3);
        #1;
        check_outs("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive_idle();
        #1;
        check_eq("lu_rs.stall_cnt", {16'd0, stall_cnt}, 32'd1);
        check_eq("lu_rs.state", {30'd0, dbg_state}, {30'd0, S_RUN});
        check_outs("lu_rs.after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Load-use on rt with opcode 1001.
        drive_lw_use(4'b1001, 4'd1, 4'd6, 4'd6);
        #1;
        check_outs("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive_idle();
        #1;
        check_eq("lu_rt.stall_cnt", {16'd0, stall_cnt}, 32'd2);

        // Branch beats hazard and halt.
        drive_lw_use(4'b0000, 4'd4, 4'd7, 4'd4);
        br_taken = 1'b1;
        id_halt  = 1'b1;
        #1;
        check_eq("br.pc_write",    {31'd0, pc_write},    32'd1);
        check_eq("br.ifid_flush",  {31'd0, ifid_flush},  32'd1);
        check_eq("br.idex_bubble", {31'd0, idex_bubble}, 32'd1);
        step();
        drive_idle();
        #1;
        check_eq("br.flush_cnt", {16'd0, flush_cnt}, 32'd1);
        check_eq("br.stall_cnt", {16'd0, stall_cnt}, 32'd2);
        check_eq("br.state", {30'd0, dbg_state}, {30'd0, S_RUN});

        // Hazard with halt: stall wins, halt taken next cycle.
        drive_lw_use(4'b0000, 4'd4, 4'd7, 4'd4);
        id_halt = 1'b1;
        #1;
        check_outs("lu_halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check_eq("lu_halt.state", {30'd0, dbg_state}, {30'd0, S_RUN});
        check_eq("lu_halt.stall_cnt", {16'd0, stall_cnt}, 32'd3);
        drive_idle();
        id_halt = 1'b1;
        #1;
        check_outs("halt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("halt.state", {30'd0, dbg_state}, {30'd0, S_DRAIN});
        check_eq("sat.halt.state", {30'd0, s_dbg_state}, {30'd0, S_DRAIN});
        check_eq("sat.halt.halted0", {31'd0, s_halted}, 32'd0);

        // DRAIN for three cycles, events ignored.
        for (int i = 0; i < 3; i++) begin
            drive_lw_use(4'b0000, 4'd4, 4'd7, 4'd4);
            br_taken = 1'b1;
            id_halt  = 1'b1;
            #1;
            check_outs("drain", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            check_eq("drain.state", {30'd0, dbg_state}, {30'd0, S_DRAIN});
            step();
            if (i == 0) check_eq("sat.halted1", {31'd0, s_halted}, 32'd1);
        end
        check_eq("halted.state", {30'd0, dbg_state}, {30'd0, S_HALT});
        check_outs("halted", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("drain.stall_cnt", {16'd0, stall_cnt}, 32'd3);
        check_eq("drain.flush_cnt", {16'd0, flush_cnt}, 32'd1);

        // HALT is sticky for 100 cycles with br_taken toggling.
        drive_idle();
        for (int i = 0; i < 100; i++) begin
            br_taken = i[0];
            #1;
            check_eq("hold.halted", {31'd0, halted}, 32'd1);
            step();
        end
        check_eq("hold.flush_cnt", {16'd0, flush_cnt}, 32'd1);

        // Reset during the second DRAIN cycle aborts the sequence.
        drive_idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive_lw_use(4'b0000, 4'd4, 4'd7, 4'd4);
        step();
        drive_idle();
        id_halt = 1'b1;
        step();
        drive_idle();
        step();
        check_eq("abort.pre_state", {30'd0, dbg_state}, {30'd0, S_DRAIN});
        check_eq("abort.pre_stall", {16'd0, stall_cnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_outs("abort.rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("abort.state", {30'd0, dbg_state}, {30'd0, S_RUN});
        check_eq("abort.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check_eq("abort.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        check_outs("abort.run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Saturation: 2^4+5 hazard cycles into the CNT_W=4 instance.
        drive_lw_use(4'b0001, 4'd9, 4'd2, 4'd9);
        for (int i = 0; i < 21; i++) begin
            step();
            if (i == 14) check_eq("sat.at15", {28'd0, s_stall_cnt}, 32'd15);
        end
        check_eq("sat.hold15", {28'd0, s_stall_cnt}, 32'd15);
        check_eq("wide.stall21", {16'd0, stall_cnt}, 32'd21);
        drive_idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
